// File: rtl/mix_char_in_if.sv
// CPU/UART side signal bundle of the MIX character input unit.
// master drives the IN request, the received bytes and store; slave is the unit.
interface mix_char_in_if #(
  parameter int ADDR_W         = 12,
  parameter int CHAR_W         = 6,
  parameter int BYTES_PER_WORD = 5
);
  logic                             start;
  logic [5:0]                       field;
  logic [ADDR_W-1:0]                addressin;
  logic [7:0]                       rx_data;
  logic                             rx_valid;
  logic                             store;
  logic [BYTES_PER_WORD*CHAR_W-1:0] out;
  logic [ADDR_W-1:0]                addressout;
  logic                             request;
  logic                             stop;
  logic                             busy;
  logic                             overflow;

  modport master (
    output start, field, addressin, rx_data, rx_valid, store,
    input  out, addressout, request, stop, busy, overflow
  );

  modport slave (
    input  start, field, addressin, rx_data, rx_valid, store,
    output out, addressout, request, stop, busy, overflow
  );
endinterface

// File: rtl/mix_char_in_unit.sv
// MIX IN unit: FIFO-buffered serial bytes translated to MIX codes, packed into
// words and handed to the CPU one word per request/store handshake.
module mix_char_in_unit #(
  parameter int ADDR_W         = 12,
  parameter int CHAR_W         = 6,
  parameter int BYTES_PER_WORD = 5,
  parameter int FIFO_DEPTH     = 16,
  parameter int CARD_UNIT      = 16,
  parameter int CARD_WORDS     = 16,
  parameter int TERM_UNIT      = 19,
  parameter int TERM_WORDS     = 14
) (
  input logic         clk,
  input logic         reset,
  mix_char_in_if.slave bus
);

  localparam int WORD_W    = BYTES_PER_WORD * CHAR_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CC_W      = $clog2(BYTES_PER_WORD);
  localparam int MAX_WORDS = (CARD_WORDS > TERM_WORDS) ? CARD_WORDS : TERM_WORDS;
  localparam int WC_W      = $clog2(MAX_WORDS + 1);

  localparam logic [5:0]      CARD_U    = 6'(CARD_UNIT);
  localparam logic [5:0]      TERM_U    = 6'(TERM_UNIT);
  localparam logic [WC_W-1:0] CARD_LEN  = WC_W'(CARD_WORDS);
  localparam logic [WC_W-1:0] TERM_LEN  = WC_W'(TERM_WORDS);
  localparam logic [CC_W-1:0] LAST_CHAR = CC_W'(BYTES_PER_WORD - 1);
  localparam logic [PTR_W:0]  FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_STORE} state_t;

  function automatic logic [CHAR_W-1:0] map_char(input logic [7:0] b);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    map_char = '0;
    if (u >= 8'h41 && u <= 8'h49)      map_char = CHAR_W'(u - 8'h41 + 8'd1);
    else if (u >= 8'h4A && u <= 8'h52) map_char = CHAR_W'(u - 8'h4A + 8'd11);
    else if (u >= 8'h53 && u <= 8'h5A) map_char = CHAR_W'(u - 8'h53 + 8'd22);
    else if (u >= 8'h30 && u <= 8'h39) map_char = CHAR_W'(u - 8'h30 + 8'd30);
    else begin
      case (u)
        8'h2E:   map_char = CHAR_W'(40);
        8'h2C:   map_char = CHAR_W'(41);
        8'h28:   map_char = CHAR_W'(42);
        8'h29:   map_char = CHAR_W'(43);
        8'h2B:   map_char = CHAR_W'(44);
        8'h2D:   map_char = CHAR_W'(45);
        8'h2A:   map_char = CHAR_W'(46);
        8'h2F:   map_char = CHAR_W'(47);
        8'h3D:   map_char = CHAR_W'(48);
        8'h24:   map_char = CHAR_W'(49);
        8'h3C:   map_char = CHAR_W'(50);
        8'h3E:   map_char = CHAR_W'(51);
        8'h40:   map_char = CHAR_W'(52);
        8'h3B:   map_char = CHAR_W'(53);
        8'h3A:   map_char = CHAR_W'(54);
        8'h27:   map_char = CHAR_W'(55);
        default: map_char = '0;
      endcase
    end
  endfunction

  state_t            state, state_nxt;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [5:0]        unit;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend, pad;
  logic [CC_W-1:0]   char_cnt;
  logic [WC_W-1:0]   word_cnt;

  logic              fifo_empty, fifo_full, push, pop;
  logic [7:0]        head;
  logic              head_ctrl, take_char, word_done;
  logic              start_idle, start_busy, accept_store, block_done, pend_now;
  logic [ADDR_W-1:0] pend_addr_now;
  logic [WC_W-1:0]   blk_len, word_cnt_inc;
  logic [CHAR_W-1:0] new_char;

  assign fifo_empty    = (fifo_cnt == '0);
  assign fifo_full     = (fifo_cnt == FULL_CNT);
  assign push          = bus.rx_valid && (!fifo_full || pop);
  assign head          = fifo_mem[rd_ptr];
  assign head_ctrl     = (head < 8'h20) || (head == 8'h7F);
  assign take_char     = (state == FILL) && (pad || (!fifo_empty && !head_ctrl));
  assign new_char      = pad ? '0 : map_char(head);
  assign word_done     = take_char && (char_cnt == LAST_CHAR);
  assign start_idle    = bus.start && !bus.busy;
  assign start_busy    = bus.start && bus.busy;
  assign accept_store  = (state == WAIT_STORE) && bus.request && bus.store;
  assign blk_len       = (unit == CARD_U) ? CARD_LEN : TERM_LEN;
  assign word_cnt_inc  = word_cnt + 1'b1;
  assign block_done    = accept_store && (word_cnt_inc == blk_len);
  // A start coinciding with the block-ending store still counts as queued.
  assign pend_now      = pend || start_busy;
  assign pend_addr_now = pend ? pend_addr : bus.addressin;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (start_idle && (bus.field == CARD_U || bus.field == TERM_U)) state_nxt = FILL;
      end
      FILL: begin
        pop = !pad && !fifo_empty;
        if (word_done) state_nxt = WAIT_STORE;
      end
      WAIT_STORE: begin
        if (accept_store) state_nxt = (block_done && !pend_now) ? IDLE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.rx_data;
    if (start_busy && !pend) pend_addr <= bus.addressin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      unit           <= '0;
      pend           <= 1'b0;
      pad            <= 1'b0;
      char_cnt       <= '0;
      word_cnt       <= '0;
      bus.out        <= '0;
      bus.addressout <= '0;
      bus.request    <= 1'b0;
      bus.stop       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.stop <= 1'b0;
      bus.busy <= (state_nxt != IDLE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      if (bus.rx_valid && fifo_full && !pop) bus.overflow <= 1'b1;

      if (start_idle) begin
        unit           <= bus.field;
        bus.addressout <= bus.addressin;
        bus.stop       <= 1'b1;
      end
      if (pop && head == 8'h0D && unit == TERM_U) pad <= 1'b1;
      if (take_char) begin
        bus.out  <= {bus.out[WORD_W-CHAR_W-1:0], new_char};
        char_cnt <= word_done ? '0 : char_cnt + 1'b1;
        if (word_done) bus.request <= 1'b1;
      end

      if (accept_store) begin
        bus.request    <= 1'b0;
        bus.out        <= '0;
        bus.addressout <= bus.addressout + 1'b1;
        if (block_done) begin
          pad      <= 1'b0;
          word_cnt <= '0;
          if (pend_now) begin
            pend           <= 1'b0;
            bus.addressout <= pend_addr_now;
            bus.stop       <= 1'b1;
          end
        end else begin
          word_cnt <= word_cnt_inc;
        end
      end
      if (start_busy && !pend && !block_done) pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mix_char_in_unit.sv
// Directed bench for mix_char_in_unit: card and terminal blocks, queued IN,
// FIFO overflow, non-transfer unit, address wrap and mid-block reset.
module tb_mix_char_in_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mix_char_in_if #(.ADDR_W(12), .CHAR_W(6), .BYTES_PER_WORD(5)) bus ();

  mix_char_in_unit #(
    .ADDR_W(12), .CHAR_W(6), .BYTES_PER_WORD(5), .FIFO_DEPTH(16),
    .CARD_UNIT(16), .CARD_WORDS(16), .TERM_UNIT(19), .TERM_WORDS(14)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {6'(a), 6'(b), 6'(c), 6'(d), 6'(e)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic [7:0] e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  task automatic issue(input logic [5:0] f, input logic [11:0] a);
    bus.start     = 1'b1;
    bus.field     = f;
    bus.addressin = a;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 40 && bus.request !== 1'b1; i++) step();
    chk(tag, 64'(bus.request), 64'd1);
  endtask

  task automatic do_store();
    bus.store = 1'b1;
    step();
    bus.store = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.field = '0; bus.addressin = '0;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.store = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_req", 64'(bus.request), 64'd0);
    chk("rst_flags", 64'({bus.stop, bus.busy, bus.overflow}), 64'd0);
    chk("rst_addr", 64'(bus.addressout), 64'd0);
    reset = 1'b0;
    step();

    // Card block at 100, alphabet repeating.
    issue(6'd16, 12'd100);
    chk("card_stop", 64'(bus.stop), 64'd1);
    chk("card_busy", 64'(bus.busy), 64'd1);
    chk("card_addr0", 64'(bus.addressout), 64'd100);
    step();
    chk("card_stop_clr", 64'(bus.stop), 64'd0);
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 5; k++) send(8'(65 + (w * 5 + k) % 26));
      wait_req("card_req");
      chk("card_addr", 64'(bus.addressout), 64'(100 + w));
      if (w == 0) chk("card_w0", 64'(bus.out), 64'(pk(1, 2, 3, 4, 5)));
      if (w == 5) chk("card_w5", 64'(bus.out), 64'(pk(29, 1, 2, 3, 4)));
      do_store();
      chk("card_req_clr", 64'(bus.request), 64'd0);
      chk("card_busy_blk", 64'(bus.busy), (w == 15) ? 64'd0 : 64'd1);
    end

    // Terminal: "Hi" then CR pads the rest of the block with blanks.
    issue(6'd19, 12'd300);
    chk("term_stop", 64'(bus.stop), 64'd1);
    send(8'h48); send(8'h69); send(8'h0D);
    for (int w = 0; w < 14; w++) begin
      wait_req("term_req");
      chk("term_addr", 64'(bus.addressout), 64'(300 + w));
      chk("term_out", 64'(bus.out), (w == 0) ? 64'(pk(8, 9, 0, 0, 0)) : 64'd0);
      do_store();
    end
    chk("term_busy_end", 64'(bus.busy), 64'd0);

    // Queued IN: second start at 500 held until block ends, third ignored.
    issue(6'd19, 12'd200);
    chk("q_stop1", 64'(bus.stop), 64'd1);
    issue(6'd19, 12'd500);
    chk("q_no_stop2", 64'(bus.stop), 64'd0);
    issue(6'd19, 12'd700);
    chk("q_no_stop3", 64'(bus.stop), 64'd0);
    send(8'h0D);
    for (int w = 0; w < 14; w++) begin
      wait_req("q_req");
      chk("q_addr", 64'(bus.addressout), 64'(200 + w));
      do_store();
      chk("q_stop_blk", 64'(bus.stop), (w == 13) ? 64'd1 : 64'd0);
    end
    chk("q_busy_hold", 64'(bus.busy), 64'd1);
    chk("q_addr_pend", 64'(bus.addressout), 64'd500);
    step();
    chk("q_stop_pulse", 64'(bus.stop), 64'd0);
    send5(8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
    wait_req("q2_req");
    chk("q2_addr", 64'(bus.addressout), 64'd500);
    chk("q2_out", 64'(bus.out), 64'(pk(1, 2, 3, 4, 5)));
    do_store();
    send(8'h0D);
    for (int w = 1; w < 14; w++) begin
      wait_req("q2_pad_req");
      do_store();
    end
    chk("q2_busy_end", 64'(bus.busy), 64'd0);
    chk("q2_no_stop", 64'(bus.stop), 64'd0);

    // Unit 5: stop pulse only.
    issue(6'd5, 12'd42);
    chk("u5_stop", 64'(bus.stop), 64'd1);
    chk("u5_busy", 64'(bus.busy), 64'd0);
    step(); step();
    chk("u5_req", 64'(bus.request), 64'd0);
    chk("u5_busy2", 64'(bus.busy), 64'd0);

    // Overflow: 20 bytes arrive while the first word waits for store.
    issue(6'd16, 12'd0);
    send5(8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
    wait_req("ov_req");
    for (int k = 0; k < 20; k++) begin
      send(8'(70 + k));
      if (k == 15) chk("ov_not_yet", 64'(bus.overflow), 64'd0);
      if (k == 16) chk("ov_set", 64'(bus.overflow), 64'd1);
    end
    chk("ov_req_hold", 64'(bus.request), 64'd1);
    chk("ov_out_hold", 64'(bus.out), 64'(pk(1, 2, 3, 4, 5)));
    chk("ov_addr_hold", 64'(bus.addressout), 64'd0);
    do_store();
    wait_req("ov_req1");
    chk("ov_w1", 64'(bus.out), 64'(pk(6, 7, 8, 9, 11)));
    do_store();
    wait_req("ov_req2");
    chk("ov_w2", 64'(bus.out), 64'(pk(12, 13, 14, 15, 16)));
    do_store();
    wait_req("ov_req3");
    chk("ov_w3", 64'(bus.out), 64'(pk(17, 18, 19, 22, 23)));
    do_store();
    send(8'h5A); send(8'h5A); send(8'h5A); send(8'h5A);
    wait_req("ov_req4");
    chk("ov_w4", 64'(bus.out), 64'(pk(24, 29, 29, 29, 29)));
    chk("ov_sticky", 64'(bus.overflow), 64'd1);

    // Reset mid-block with bytes still queued in the FIFO.
    send(8'h51); send(8'h51); send(8'h51);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_out", 64'(bus.out), 64'd0);
    chk("mid_rst_addr", 64'(bus.addressout), 64'd0);
    chk("mid_rst_flags", 64'({bus.request, bus.stop, bus.busy, bus.overflow}), 64'd0);
    step();

    // Address wrap and punctuation mapping; control byte 0x01 dropped.
    issue(6'd16, 12'd4094);
    chk("wr_addr0", 64'(bus.addressout), 64'd4094);
    send(8'h7A); send(8'h39); send(8'h01); send(8'h2E); send(8'h27); send(8'h23);
    wait_req("wr_req0");
    chk("wr_w0", 64'(bus.out), 64'(pk(29, 39, 40, 55, 0)));
    do_store();
    send5(8'h24, 8'h3C, 8'h40, 8'h3A, 8'h2A);
    wait_req("wr_req1");
    chk("wr_addr1", 64'(bus.addressout), 64'd4095);
    chk("wr_w1", 64'(bus.out), 64'(pk(49, 50, 52, 54, 46)));
    do_store();
    send5(8'h2D, 8'h28, 8'h29, 8'h2B, 8'h2F);
    wait_req("wr_req2");
    chk("wr_addr2", 64'(bus.addressout), 64'd0);
    chk("wr_w2", 64'(bus.out), 64'(pk(45, 42, 43, 44, 47)));
    do_store();
    send5(8'h3D, 8'h3E, 8'h3B, 8'h2C, 8'h20);
    wait_req("wr_req3");
    chk("wr_addr3", 64'(bus.addressout), 64'd1);
    chk("wr_w3", 64'(bus.out), 64'(pk(48, 51, 53, 41, 0)));

    // Reset right after power-on-style state must leave the FIFO empty.
    send(8'h52);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    issue(6'd16, 12'd10);
    send5(8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
    wait_req("fe_req");
    chk("fe_w0", 64'(bus.out), 64'(pk(1, 2, 3, 4, 5)));
    chk("fe_addr", 64'(bus.addressout), 64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mix_char_in_unit.md
Name: mix_char_in_unit

Overview:
- Parametrised MIX character input unit (IN instruction) serving the card reader and the terminal from one serial byte stream.
- Buffers received bytes in a FIFO, translates ASCII to MIX 6-bit codes, packs them into words and hands each word to the CPU through a request/store handshake for block transfer to memory.
- Supports one queued IN while busy, per-unit block length, CR padding on the terminal, and a sticky overflow flag.

Parameters:
- ADDR_W, 12, memory address width
- CHAR_W, 6, MIX character width
- BYTES_PER_WORD, 5, characters per word
- FIFO_DEPTH, 16, receive FIFO entries; power of 2, at least 2
- CARD_UNIT, 16, unit number of the card reader
- CARD_WORDS, 16, words per card block
- TERM_UNIT, 19, unit number of the terminal
- TERM_WORDS, 14, words per terminal block

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- start  in  1  CPU issues IN, one-cycle pulse
- field  in  6  unit number, sampled with start
- addressin  in  ADDR_W  block start address, sampled with start
- rx_data  in  8  received byte from the UART
- rx_valid  in  1  rx_data valid, one-cycle pulse
- store  in  1  CPU has written out to memory at addressout
- out  out  BYTES_PER_WORD*CHAR_W  packed word; first character is in the most-significant field
- addressout  out  ADDR_W  destination address of out
- request  out  1  word ready for the CPU
- stop  out  1  one-cycle pulse: CPU may resume
- busy  out  1  block transfer in progress
- overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset: all outputs are 0 and the FIFO is empty. Reset mid-transfer aborts the transfer and discards all pending state.
- FIFO write and overflow:
  - Every rx_valid byte is written to the FIFO, including while idle (type-ahead).
  - If the FIFO is full, the byte is dropped and overflow is set. overflow clears only on reset.
  - A simultaneous write and pop on a full FIFO is accepted.
- start while not busy:
  - Latch field as the current unit and addressin into addressout.
  - Next cycle, stop=1 for one cycle.
  - busy=1 from the next cycle only if the unit is CARD_UNIT or TERM_UNIT. Any other unit gives the stop pulse only, with no transfer.
- start while busy:
  - Latch addressin as the pending address and set the pending flag.
  - No stop pulse is issued, so the CPU stays stalled.
  - A second start while the pending flag is already set is ignored.
- State machine: IDLE -> FILL -> WAIT_STORE -> (FILL | IDLE | FILL at the pending address).
- FILL:
  - Pop at most one byte per cycle while the FIFO is non-empty. Each accepted character shifts out left by CHAR_W, with the new character in the LSBs.
  - Bytes 0x00-0x1F and 0x7F are dropped and do not count, except CR (0x0D) on the terminal, which enters PAD mode.
  - Lowercase letters map as uppercase. Other bytes map to code 0.
  - Mapping:
    - space -> 0
    - A-I -> 1-9, J-R -> 11-19, S-Z -> 22-29
    - 0-9 -> 30-39
    - . -> 40, , -> 41, ( -> 42, ) -> 43, + -> 44, - -> 45, * -> 46, / -> 47
    - = -> 48, $ -> 49, < -> 50, > -> 51, @ -> 52, ; -> 53, : -> 54, ' -> 55
- PAD mode: insert one code-0 character per cycle without popping, until the block completes.
- End of word: the cycle after the BYTES_PER_WORD-th character, request=1 and the state is WAIT_STORE. out and addressout stay stable while request=1.
- WAIT_STORE: store is honoured only while request=1. On store&request:
  - request=0 and out is cleared.
  - addressout increments, wrapping modulo 2^ADDR_W.
  - The word count increments.
  - If the word count reaches the unit's block length (CARD_WORDS or TERM_WORDS), the block is done. Otherwise return to FILL.
- Block done:
  - Clear PAD mode and the word count.
  - If the pending flag is set: clear it, load addressout from the pending address, pulse stop next cycle and stay busy.
  - Otherwise busy=0 next cycle.
- Ignored inputs: store without request is ignored; start in the same cycle as a store is handled as start while busy.

Test Plan:
- Card, unit 16, addressin 100, then 80 bytes "ABCDE..." -> stop pulse 1 cycle after start; first word 100 = {1,2,3,4,5}; 16 requests at addresses 100..115; busy falls after the 16th store.
- Terminal, unit 19, bytes "HI" then CR -> word 0 = {8,9,0,0,0}; remaining 13 words all zero; 14 stores total, then busy=0.
- start unit 19 at 200, then a second start at 500 while busy -> no second stop until block 1 ends; stop pulse at block end; next request addressout=500.
- Hold store low for 20 cycles while 20 bytes arrive (FIFO_DEPTH=16) -> request held with out stable; overflow=1; exactly 16 bytes are later consumed.
- start with field=5 -> stop pulse, busy stays 0, no request.
- addressin 4094 on card -> addresses 4094, 4095, 0, 1, ...; reset mid-block -> all outputs 0, FIFO empty, overflow cleared.
